// File: rtl/dither_scan_sequencer.sv
// Raster-scan initiator: walks an IMG_W x IMG_H frame in row-major order, one trigger per pixel.
// Optional WAIT_FIN watchdog is compiled in with `define DITHER_SCAN_TIMEOUT_EN.
module dither_scan_sequencer #(
  parameter int IMG_W          = 320,
  parameter int IMG_H          = 240,
  parameter int TIMEOUT_CYCLES = 15,
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int AW = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          compute_fin,
  output logic          algorithm_trigger,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic [AW-1:0] pixel_addr,
  output logic          busy,
  output logic          frame_done,
  output logic          proto_err,
  output logic          timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_FIN,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          perr_q, perr_d;
  logic          x_last, y_last;

`ifdef DITHER_SCAN_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
`endif

  assign x_last = (x_q == XW'(IMG_W - 1));
  assign y_last = (y_q == YW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      perr_q  <= 1'b0;
`ifdef DITHER_SCAN_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      perr_q  <= perr_d;
`ifdef DITHER_SCAN_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    perr_d  = perr_q;
`ifdef DITHER_SCAN_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          perr_d  = 1'b0;
`ifdef DITHER_SCAN_TIMEOUT_EN
          terr_d  = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_FIN;
`ifdef DITHER_SCAN_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT_FIN: begin
        if (compute_fin) begin
          state_d = S_ADVANCE;
        end
`ifdef DITHER_SCAN_TIMEOUT_EN
        // A fin arriving on the limit cycle takes priority over the timeout.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_ADVANCE: begin
        if (x_last && y_last) begin
          state_d = S_DONE;
        end else if (x_last) begin
          state_d = S_ISSUE;
          x_d     = '0;
          y_d     = y_q + YW'(1);
          addr_d  = addr_q + AW'(1);
        end else begin
          state_d = S_ISSUE;
          x_d     = x_q + XW'(1);
          addr_d  = addr_q + AW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A stray fin never moves the FSM; it only raises the sticky flag.
    if (compute_fin && (state_q != S_WAIT_FIN)) begin
      perr_d = 1'b1;
    end
  end

  assign algorithm_trigger = (state_q == S_ISSUE);
  assign busy              = (state_q != S_IDLE);
  assign frame_done        = (state_q == S_DONE);
  assign pixel_x           = x_q;
  assign pixel_y           = y_q;
  assign pixel_addr        = addr_q;
  assign proto_err         = perr_q;
`ifdef DITHER_SCAN_TIMEOUT_EN
  assign timeout_err       = terr_q;
`else
  assign timeout_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dither_scan_sequencer.sv
// Self-checking bench for dither_scan_sequencer on a small 4x3 frame with randomized fin latency.
module tb_dither_scan_sequencer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int TO = 15;
  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = 5 + XW + YW + AW;

  logic          clk = 1'b0;
  logic          rst, start, compute_fin;
  logic          algorithm_trigger, busy, frame_done, proto_err, timeout_err;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic [AW-1:0] pixel_addr;
  logic [VW-1:0] obs;
  int            nchecks = 0;
  int            nerr    = 0;

  always #5 clk = ~clk;

  dither_scan_sequencer #(.IMG_W(W), .IMG_H(H), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .compute_fin(compute_fin),
    .algorithm_trigger(algorithm_trigger), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_addr(pixel_addr), .busy(busy), .frame_done(frame_done),
    .proto_err(proto_err), .timeout_err(timeout_err)
  );

  assign obs = {algorithm_trigger, busy, frame_done, proto_err, timeout_err,
                pixel_x, pixel_y, pixel_addr};

  // Expected output vector: {trigger, busy, frame_done, proto_err, timeout_err, x, y, addr}
  function automatic logic [VW-1:0] pack(input logic t, input logic b, input logic f,
                                         input logic p, input logic o,
                                         input int x, input int y, input int a);
    return {t, b, f, p, o, XW'(x), YW'(y), AW'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from IDLE. lat=0 picks a random fin latency per pixel.
  // stray_pix: pixel whose ISSUE cycle also carries compute_fin. rst_pix: pixel reset in WAIT_FIN.
  task automatic run_frame(input int lat, input bit keep_start, input int stray_pix,
                           input int rst_pix);
    int L, ticks, expticks, x, y;
    bit pe;
    logic [VW-1:0] e;
    pe = 1'b0;
    ticks = 0;
    expticks = 1;
    start = 1'b1;
    tick(); ticks++;
    if (!keep_start) start = 1'b0;
    for (int p = 0; p < N; p++) begin
      x = p % W;
      y = p / W;
      e = pack(1, 1, 0, pe, 0, x, y, y * W + x);
      nchecks++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL issue pix%0d: got %h expected %h", p, obs, e);
      end
      if (p == stray_pix) compute_fin = 1'b1;
      L = (lat > 0) ? lat : int'($urandom_range(1, 6));
      expticks += L + 2;
      for (int k = 1; k <= L; k++) begin
        tick(); ticks++;
        compute_fin = 1'b0;
        if (p == stray_pix) pe = 1'b1;
        e = pack(0, 1, 0, pe, 0, x, y, y * W + x);
        nchecks++;
        if (obs !== e) begin
          nerr++;
          $display("FAIL wait pix%0d k%0d: got %h expected %h", p, k, obs, e);
        end
        if (p == rst_pix) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          e = pack(0, 0, 0, 0, 0, 0, 0, 0);
          nchecks++;
          if (obs !== e) begin
            nerr++;
            $display("FAIL midframe_rst: got %h expected %h", obs, e);
          end
          tick();
          nchecks++;
          if (obs !== e) begin
            nerr++;
            $display("FAIL after_rst_idle: got %h expected %h", obs, e);
          end
          return;
        end
        if (k == L) compute_fin = 1'b1;
      end
      tick(); ticks++;
      compute_fin = 1'b0;
      e = pack(0, 1, 0, pe, 0, x, y, y * W + x);
      nchecks++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL advance pix%0d: got %h expected %h", p, obs, e);
      end
      tick(); ticks++;
    end
    e = pack(0, 1, 1, pe, 0, W - 1, H - 1, N - 1);
    nchecks++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL done: got %h expected %h", obs, e);
    end
    nchecks++;
    if (ticks !== expticks) begin
      nerr++;
      $display("FAIL frame_latency: got %0d cycles expected %0d", ticks, expticks);
    end
    tick();
    e = pack(0, 0, 0, pe, 0, W - 1, H - 1, N - 1);
    nchecks++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL idle_after_done: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    e = pack(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; start = 1'b1; compute_fin = 1'b0;
    tick();
    nchecks++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL reset_with_start: got %h expected %h", obs, e);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    nchecks++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL reset_idle: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_frame_fixed();
    run_frame(3, 1'b0, -1, -1);
  endtask

  task automatic test_frame_random();
    for (int i = 0; i < 3; i++) run_frame(0, 1'b0, -1, -1);
  endtask

  task automatic test_start_held();
    run_frame(0, 1'b1, -1, -1);
    run_frame(3, 1'b1, -1, -1);
    start = 1'b0;
    tick();
  endtask

  task automatic test_proto_err();
    logic [VW-1:0] e;
    compute_fin = 1'b1;
    tick();
    compute_fin = 1'b0;
    e = pack(0, 0, 0, 1, 0, W - 1, H - 1, N - 1);
    nchecks++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL stray_fin_idle: got %h expected %h", obs, e);
    end
    run_frame(0, 1'b0, 2, -1);
    run_frame(0, 1'b0, -1, -1);
  endtask

  task automatic test_reset_midframe();
    run_frame(3, 1'b0, -1, 5);
    run_frame(0, 1'b0, -1, -1);
  endtask

`ifdef DITHER_SCAN_TIMEOUT_EN
  task automatic test_timeout();
    logic [VW-1:0] e;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      e = pack(0, 1, 0, 0, 0, 0, 0, 0);
      nchecks++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL timeout_wait k%0d: got %h expected %h", k, obs, e);
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      e = pack(0, 0, 0, 0, 1, 0, 0, 0);
      nchecks++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL timeout_idle c%0d: got %h expected %h", k, obs, e);
      end
    end
    run_frame(TO, 1'b0, -1, -1);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; compute_fin = 1'b0;
    tick();
    tick();
    test_reset();
    test_frame_fixed();
    test_frame_random();
    test_start_held();
    test_proto_err();
    test_reset_midframe();
`ifdef DITHER_SCAN_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/dither_scan_sequencer.md
# dither_scan_sequencer

Raster-scan initiator for the per-pixel dithering loop controller. On `start` it walks every pixel of an `IMG_W` x `IMG_H` frame in row-major order. For each pixel it:
- presents the pixel coordinates and linear address;
- issues a one-cycle `algorithm_trigger`;
- waits for the controller's `compute_fin` strobe, then advances.

It sits between the frame/host control logic and the dithering loop controller. It ensures the controller receives exactly one trigger per pixel and never receives a trigger while it is mid-sequence.

## Interface
Parameters:
- IMG_W, default 320: frame width in pixels (>= 1).
- IMG_H, default 240: frame height in pixels (>= 1).
- TIMEOUT_CYCLES, default 15: watchdog limit, in cycles spent in WAIT_FIN (used only with the watchdog compiled in).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- compute_fin  in  1  per-pixel completion strobe from the loop controller.
- algorithm_trigger  out  1  one-cycle per-pixel trigger to the loop controller.
- pixel_x  out  $clog2(IMG_W) (min 1)  current column.
- pixel_y  out  $clog2(IMG_H) (min 1)  current row.
- pixel_addr  out  $clog2(IMG_W*IMG_H) (min 1)  linear address, y*IMG_W + x.
- busy  out  1  high from ISSUE of the first pixel through DONE.
- frame_done  out  1  one-cycle pulse when the last pixel has completed.
- proto_err  out  1  sticky; set when `compute_fin` arrives outside WAIT_FIN.
- timeout_err  out  1  sticky watchdog flag; constant 0 when the watchdog is compiled out.

## Operation
- States: IDLE, ISSUE, WAIT_FIN, ADVANCE, DONE.
- IDLE:
  - `start`=1 -> ISSUE; clears `proto_err` and `timeout_err`; zeroes x, y and addr.
  - otherwise stay in IDLE.
- ISSUE: `algorithm_trigger`=1 for this cycle only -> WAIT_FIN.
- WAIT_FIN:
  - `compute_fin`=1 -> ADVANCE.
  - otherwise stay in WAIT_FIN.
- ADVANCE: update coordinates, then:
  - if x==IMG_W-1 and y==IMG_H-1 -> DONE, coordinates unchanged;
  - else if x==IMG_W-1: x<=0, y<=y+1, addr<=addr+1 -> ISSUE;
  - else: x<=x+1, addr<=addr+1 -> ISSUE.
- DONE: `frame_done`=1 -> IDLE.
- `pixel_addr` is maintained incrementally with an adder; no multiplier.
- x, y and addr are held stable from ISSUE through ADVANCE of each pixel. They hold their final values in IDLE until the next `start`.
- `start` is ignored outside IDLE. Frames do not auto-restart.
- `compute_fin` outside WAIT_FIN sets `proto_err` and is otherwise ignored; the FSM does not change state.
- `compute_fin` coincident with ISSUE is a protocol error. It does not satisfy the upcoming wait.
- `algorithm_trigger`, `busy` and `frame_done` are decoded from registered state, with no combinational path from any input.

## Timing
- Reset values: state IDLE; all outputs 0 (x, y, addr, trigger, busy, frame_done, proto_err, timeout_err).
- `rst` overrides everything including mid-frame. The next cycle is IDLE with all outputs 0. No trigger is issued in the cycle `rst` is high.
- Frame start: `start` high in IDLE at cycle c gives ISSUE and the first trigger at c+1.
- Against the loop controller, `compute_fin` arrives 3 cycles after the trigger. Per-pixel period is therefore 5 cycles: ISSUE, WAIT_FIN x3, ADVANCE.
- The next trigger fires 5 cycles after the previous one. By then the controller is back in its WAIT state.
- The sequencer accepts arbitrary `compute_fin` latency (>= 1 cycle) with the watchdog out.
- Frame latency: the start pulse at c gives `frame_done` at c + 5*IMG_W*IMG_H + 1 and IDLE at the cycle after.
- IMG_W=1 and/or IMG_H=1 are legal; the wrap and last-pixel conditions may coincide.

## Configuration
- Macro: `DITHER_SCAN_TIMEOUT_EN`.
- Defined:
  - a counter resets on entry to WAIT_FIN and increments each WAIT_FIN cycle without `compute_fin`;
  - when it reaches TIMEOUT_CYCLES, `timeout_err` is set (sticky) and the FSM goes to IDLE;
  - on timeout, `frame_done` is not pulsed and `busy` drops the next cycle;
  - `compute_fin` in the same cycle the limit is reached wins: normal ADVANCE, no error.
- Undefined: no counter; WAIT_FIN waits indefinitely; `timeout_err` is tied to 0.

## Test plan
- 2x2 frame with a model controller (fin 3 cycles after trigger), `start` at cycle 10:
  - triggers at cycles 11, 16, 21, 26;
  - (x,y,addr) = (0,0,0), (1,0,1), (0,1,2), (1,1,3);
  - `frame_done` at 31; `busy` high for cycles 11-31.
- Default 320x240 frame: exactly 76800 triggers; `frame_done` 384001 cycles after `start`; final addr 76799.
- `start` held high during a frame and after DONE: no restart mid-frame; a new frame begins only from IDLE.
- Stray `compute_fin` in IDLE and in ISSUE: `proto_err`=1 and the scan proceeds unchanged. The next `start` clears `proto_err` to 0.
- `rst` asserted in WAIT_FIN of pixel 5: next cycle everything is 0 and IDLE. A new `start` restarts at (0,0).
- `DITHER_SCAN_TIMEOUT_EN`, TIMEOUT_CYCLES=15, controller never returns fin:
  - `timeout_err`=1 and IDLE 15 cycles after entering WAIT_FIN;
  - no `frame_done`;
  - fin delivered on exactly the 15th cycle instead gives no error.
